// File: rtl/md_ctrl_pkg.sv
// HI/LO multiply/divide controller: funct codes, FSM states
// and the shared decode helper used by the controller and pipeline.
package md_ctrl_pkg;

  localparam logic [5:0] MFHI_FUNC  = 6'h10;
  localparam logic [5:0] MTHI_FUNC  = 6'h11;
  localparam logic [5:0] MFLO_FUNC  = 6'h12;
  localparam logic [5:0] MTLO_FUNC  = 6'h13;
  localparam logic [5:0] MULT_FUNC  = 6'h18;
  localparam logic [5:0] MULTU_FUNC = 6'h19;
  localparam logic [5:0] DIV_FUNC   = 6'h1a;
  localparam logic [5:0] DIVU_FUNC  = 6'h1b;

  localparam int CNT_W = 4;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // True for any instruction that reads or writes HI/LO.
  function automatic logic is_hilo(
    input logic [31:0] i
  );
    return (i[31:26] == 6'd0) &&
      (i[5:0] inside {MFHI_FUNC, MTHI_FUNC,
                      MFLO_FUNC, MTLO_FUNC,
                      MULT_FUNC, MULTU_FUNC,
                      DIV_FUNC, DIVU_FUNC});
  endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// Pipeline <-> mul/div controller bundle.
// master: EX/ID drive instructions + operands; slave: md_ctrl.
interface md_ctrl_if;
  logic [31:0] instrEX;
  logic [31:0] rsdataEX;
  logic [31:0] rtdataEX;
  logic [31:0] instrID;
  logic [31:0] hdata;
  logic [31:0] ldata;
  logic        start;
  logic        busy;
  logic        md_stall;

  modport master (
    output instrEX, rsdataEX, rtdataEX, instrID,
    input  hdata, ldata, start, busy, md_stall
  );

  modport slave (
    input  instrEX, rsdataEX, rtdataEX, instrID,
    output hdata, ldata, start, busy, md_stall
  );
endinterface

// File: rtl/md_ctrl.sv
// Mult/div latency model with HI/LO registers and ID stall request.
// Ports: clk, reset (sync, active-high), bus (md_ctrl_if.slave).
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_ctrl_if.slave  bus
);

  md_state_e        r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [31:0]      r_thi, w_thi;
  logic [31:0]      r_tlo, w_tlo;
  logic             r_dz, w_dzn;
  logic [31:0]      r_hi, w_hi;
  logic [31:0]      r_lo, w_lo;

  logic [31:0] w_rs, w_rt;
  logic [5:0]  w_fn;
  logic        w_rtype;
  logic        w_mult, w_multu, w_div, w_divu;
  logic        w_mthi, w_mtlo;
  logic        w_md, w_isdiv, w_start;

  assign w_rs    = bus.rsdataEX;
  assign w_rt    = bus.rtdataEX;
  assign w_fn    = bus.instrEX[5:0];
  assign w_rtype = bus.instrEX[31:26] == 6'd0;
  assign w_mult  = w_rtype && w_fn == MULT_FUNC;
  assign w_multu = w_rtype && w_fn == MULTU_FUNC;
  assign w_div   = w_rtype && w_fn == DIV_FUNC;
  assign w_divu  = w_rtype && w_fn == DIVU_FUNC;
  assign w_mthi  = w_rtype && w_fn == MTHI_FUNC;
  assign w_mtlo  = w_rtype && w_fn == MTLO_FUNC;
  assign w_isdiv = w_div | w_divu;
  assign w_md    = w_mult | w_multu | w_isdiv;
  assign w_start = w_md && r_state == MD_IDLE;

  logic signed [63:0] w_sprod;
  logic [63:0]        w_uprod;
  assign w_sprod = $signed({{32{w_rs[31]}}, w_rs})
                 * $signed({{32{w_rt[31]}}, w_rt});
  assign w_uprod = {32'd0, w_rs} * {32'd0, w_rt};

  // Divisor forced to 1 on /0 (result discarded) and on
  // MIN/-1, where rs/1 gives exactly LO=MIN, HI=0.
  logic        w_dz, w_ovf;
  logic [31:0] w_sdv, w_udv;
  logic signed [31:0] w_sq, w_sr;
  logic [31:0] w_uq, w_ur;
  assign w_dz  = w_rt == 32'd0;
  assign w_ovf = w_rs == 32'h8000_0000 &&
                 w_rt == 32'hffff_ffff;
  assign w_sdv = (w_dz | w_ovf) ? 32'd1 : w_rt;
  assign w_udv = w_dz ? 32'd1 : w_rt;
  assign w_sq  = $signed(w_rs) / $signed(w_sdv);
  assign w_sr  = $signed(w_rs) % $signed(w_sdv);
  assign w_uq  = w_rs / w_udv;
  assign w_ur  = w_rs % w_udv;

  logic [31:0] w_rhi, w_rlo;
  always_comb begin
    w_rhi = 32'd0;
    w_rlo = 32'd0;
    unique case (1'b1)
      w_mult:  {w_rhi, w_rlo} = w_sprod;
      w_multu: {w_rhi, w_rlo} = w_uprod;
      w_div:   begin w_rhi = w_sr; w_rlo = w_sq; end
      w_divu:  begin w_rhi = w_ur; w_rlo = w_uq; end
      default: ;
    endcase
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_thi   = r_thi;
    w_tlo   = r_tlo;
    w_dzn   = r_dz;
    w_hi    = r_hi;
    w_lo    = r_lo;
    unique case (r_state)
      MD_IDLE: begin
        if (w_start) begin
          w_thi   = w_rhi;
          w_tlo   = w_rlo;
          w_dzn   = w_isdiv & w_dz;
          w_cnt   = w_isdiv ? CNT_W'(DIV_CYCLES)
                            : CNT_W'(MULT_CYCLES);
          w_state = MD_BUSY;
        end else begin
          if (w_mthi) w_hi = w_rs;
          if (w_mtlo) w_lo = w_rs;
        end
      end
      MD_BUSY: begin
        w_cnt = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_state = MD_IDLE;
          if (!r_dz) begin
            w_hi = r_thi;
            w_lo = r_tlo;
          end
        end
      end
      default: w_state = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_thi   <= '0;
      r_tlo   <= '0;
      r_dz    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_thi   <= w_thi;
      r_tlo   <= w_tlo;
      r_dz    <= w_dzn;
      r_hi    <= w_hi;
      r_lo    <= w_lo;
    end
  end

  assign bus.hdata    = r_hi;
  assign bus.ldata    = r_lo;
  assign bus.start    = w_start;
  assign bus.busy     = r_state == MD_BUSY;
  assign bus.md_stall = (w_start | bus.busy) &
                        is_hilo(bus.instrID);

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multiply/divide controller and HI/LO register file for the 5-stage MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo from the EX stage and models the multi-cycle latency of the multiply/divide unit with a busy counter. It also raises a stall request toward the hazard unit whenever a HI/LO-related instruction in ID would observe or disturb an in-flight operation. Its `hdata`/`ldata` outputs feed the ALU forwarding path for mfhi/mflo.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `instrEX`  in  32  instruction currently in EX.
- `rsdataEX`  in  32  forwarded rs operand in EX.
- `rtdataEX`  in  32  forwarded rt operand in EX.
- `instrID`  in  32  instruction currently in ID, used for stall decision.
- `hdata`  out  32  HI register, registered.
- `ldata`  out  32  LO register, registered.
- `start`  out  1  combinational; high while a mult/multu/div/divu is in EX and the controller is IDLE.
- `busy`  out  1  registered; high while an operation is in flight.
- `md_stall`  out  1  combinational stall request to the hazard unit.

## Operation
- Decode: op==0 with funct mult 0x18, multu 0x19, div 0x1a, divu 0x1b, mfhi 0x10, mthi 0x11, mflo 0x12, mtlo 0x13. Any other instrEX is ignored.
- State machine, two states: IDLE and BUSY; 4-bit down-counter `cnt`.
- IDLE + start:
  - Compute results from rsdataEX/rtdataEX into temp_hi/temp_lo.
  - Set cnt = MULT_CYCLES or DIV_CYCLES and go to BUSY.
- BUSY:
  - Decrement cnt each cycle.
  - When cnt==1, write HI←temp_hi and LO←temp_lo on that edge, then return to IDLE.
- mult: signed 64-bit product; HI = [63:32], LO = [31:0]. multu: same, unsigned.
- div:
  - Signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned; LO = quotient, HI = remainder.
- Divide by zero, either flavour: still occupies DIV_CYCLES busy cycles; HI/LO are left unchanged at commit.
- mthi/mtlo in EX while IDLE: HI←rsdataEX or LO←rsdataEX on that edge, no busy period.
- mthi/mtlo can never reach EX during BUSY because the stall rule prevents it. If it does, it is ignored.
- md_stall = (start | busy) & instrID is any of the eight HI/LO instructions.
  - Non-HI/LO instructions keep flowing while busy.
- Reset:
  - hdata=0, ldata=0, busy=0, state=IDLE, cnt=0, temp regs=0.
  - Reset during BUSY aborts the operation; no commit occurs.

## Timing
- mult in EX in cycle T:
  - start=1 in T.
  - busy=1 in cycles T+1 … T+MULT_CYCLES.
  - HI/LO hold the new values from cycle T+MULT_CYCLES+1, when busy=0.
- div: same pattern with DIV_CYCLES.
- mfhi in ID during T is stalled through T+N and enters EX in T+N+1, where it reads the new HI. No bypass from temp regs is needed.
- Back-to-back mult→mult:
  - The second mult is stalled in ID.
  - It reaches EX in T+N+1 (start=1); busy is continuous except for that one cycle.
- mthi in EX at T: hdata shows the new value in T+1. An mfhi directly behind it is stalled by nothing and reads from ALU forwarding in T+1.
- start is never high while busy=1.
- cnt width must hold DIV_CYCLES; the counter never wraps, since the BUSY exit happens at cnt==1.

## Structure
- Add funct constants to `define.v`: `mult_func`, `multu_func`, `div_func`, `divu_func`, `mfhi_func`/`mflo_func` (already present), `mthi_func`, `mtlo_func`.
- Also add state encodings `MD_IDLE`/`MD_BUSY`.
- Single module `md_ctrl`, no sub-modules. The arithmetic is behavioural (`*`, `/`, `%` on signed/unsigned casts); the busy counter models latency.
- Top-level hazard unit ORs md_stall into its existing stall signal.

## Test plan
- After reset, mult rs=0xFFFFFFFF rt=2 → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div rs=-7 (0xFFFFFFF9) rt=2 → busy 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu 7/2 → LO=3, HI=1.
- mult in EX with mflo in ID → md_stall high for 6 cycles (start cycle + 5 busy); mflo enters EX when busy=0 and ldata holds the product. An addu in ID during busy sees md_stall=0.
- mthi 0x12345678, then mtlo 0x9ABCDEF0 back-to-back → hdata/ldata update on consecutive edges, busy never asserted. Then div by rt=0 → 10 busy cycles, and HI/LO stay 0x12345678/0x9ABCDEF0.
- div started, reset asserted in busy cycle 4 → next cycle busy=0, hdata=ldata=0, and no commit appears later.
- 0x80000000 div 0xFFFFFFFF → LO=0x80000000, HI=0. Back-to-back mult,mult → second start occurs exactly one cycle after the first busy drops.
